// File: rtl/ast_pkt_tx.sv
// Avalon-ST packet transmitter: buffers one packet from a word-write port and
// replays it on an Avalon-ST source with sop/eop under ready backpressure.
module ast_pkt_tx #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 1024
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              wr_valid_i,
  input  logic              wr_last_i,
  output logic              wr_ready_o,
  input  logic              src_ready_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              busy_o,
  output logic              trunc_o
);
  localparam int ADDR_W = $clog2(MAX_PKT_LEN);
  localparam int LEN_W  = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {LOAD_S = 2'd0, PREP_S = 2'd1, SEND_S = 2'd2} state_t;

  state_t            state_r;
  logic [DWIDTH-1:0] mem_r [MAX_PKT_LEN];
  logic [ADDR_W-1:0] w_cnt_r;
  logic [ADDR_W-1:0] r_cnt_r;
  logic [LEN_W-1:0]  w_len_r;
  logic [DWIDTH-1:0] data_r;
  logic              valid_r;
  logic              sop_r;
  logic              eop_r;
  logic              busy_r;
  logic              trunc_r;
  logic              wr_ready_r;
  logic              wr_accept_s;
  logic              src_accept_s;
  logic              last_word_s;
  logic [ADDR_W-1:0] r_nxt_s;

  // Handshake strobes, forced-last detection and next read index
  always_comb begin
    wr_accept_s  = wr_valid_i && wr_ready_r && (state_r == LOAD_S);
    src_accept_s = valid_r && src_ready_i && (state_r == SEND_S);
    last_word_s  = wr_last_i || (w_cnt_r == ADDR_W'(MAX_PKT_LEN - 1));
    r_nxt_s      = r_cnt_r + ADDR_W'(1);
  end

  // Packet buffer; unwritten entries are never read, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (wr_accept_s) begin
      mem_r[w_cnt_r] <= wr_data_i;
    end
  end

  // Load / prepare / send sequencer with registered stream outputs
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r    <= LOAD_S;
      w_cnt_r    <= '0;
      r_cnt_r    <= '0;
      w_len_r    <= '0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      sop_r      <= 1'b0;
      eop_r      <= 1'b0;
      busy_r     <= 1'b0;
      trunc_r    <= 1'b0;
      wr_ready_r <= 1'b0;
    end else begin
      trunc_r <= 1'b0;
      case (state_r)
        LOAD_S: begin
          wr_ready_r <= 1'b1;
          if (wr_accept_s) begin
            if (last_word_s) begin
              // A word accepted in the final slot closes the packet even without wr_last_i
              w_len_r    <= LEN_W'(w_cnt_r) + LEN_W'(1);
              trunc_r    <= !wr_last_i;
              wr_ready_r <= 1'b0;
              busy_r     <= 1'b1;
              state_r    <= PREP_S;
            end else begin
              w_cnt_r <= w_cnt_r + ADDR_W'(1);
            end
          end
        end
        PREP_S: begin
          r_cnt_r <= '0;
          data_r  <= mem_r[0];
          valid_r <= 1'b1;
          sop_r   <= 1'b1;
          eop_r   <= (w_len_r == LEN_W'(1));
          state_r <= SEND_S;
        end
        SEND_S: begin
          if (src_accept_s) begin
            if (eop_r) begin
              data_r     <= '0;
              valid_r    <= 1'b0;
              sop_r      <= 1'b0;
              eop_r      <= 1'b0;
              w_cnt_r    <= '0;
              busy_r     <= 1'b0;
              wr_ready_r <= 1'b1;
              state_r    <= LOAD_S;
            end else begin
              r_cnt_r <= r_nxt_s;
              data_r  <= mem_r[r_nxt_s];
              sop_r   <= 1'b0;
              eop_r   <= (LEN_W'(r_nxt_s) == (w_len_r - LEN_W'(1)));
            end
          end
        end
        default: begin
          state_r    <= LOAD_S;
          w_cnt_r    <= '0;
          valid_r    <= 1'b0;
          sop_r      <= 1'b0;
          eop_r      <= 1'b0;
          busy_r     <= 1'b0;
          wr_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready_o          = wr_ready_r;
  assign src_data_o          = data_r;
  assign src_valid_o         = valid_r;
  assign src_startofpacket_o = sop_r;
  assign src_endofpacket_o   = eop_r;
  assign busy_o              = busy_r;
  assign trunc_o             = trunc_r;

endmodule

// File: tb/tb_ast_pkt_tx.sv
// Randomized self-checking bench for ast_pkt_tx: a queue-based packet model
// predicts the beat stream, latency, truncation and handshake behaviour.
module tb_ast_pkt_tx;
  localparam int DW   = 8;
  localparam int MAXL = 1024;

  logic          clk = 1'b0;
  logic          arst_n_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_valid_i;
  logic          wr_last_i;
  logic          wr_ready_o;
  logic          src_ready_i;
  logic [DW-1:0] src_data_o;
  logic          src_valid_o;
  logic          src_startofpacket_o;
  logic          src_endofpacket_o;
  logic          busy_o;
  logic          trunc_o;

  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int trunc_cnt = 0;

  logic [DW-1:0] got_data[$];
  logic          got_sop[$];
  logic          got_eop[$];
  int            first_valid;
  int            last_beat;
  int            stable_err;
  int            wr_rdy_err;
  bit            timeout_flag;

  always #5 clk = ~clk;

  ast_pkt_tx #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_last_i(wr_last_i),
    .wr_ready_o(wr_ready_o), .src_ready_i(src_ready_i),
    .src_data_o(src_data_o), .src_valid_o(src_valid_o),
    .src_startofpacket_o(src_startofpacket_o), .src_endofpacket_o(src_endofpacket_o),
    .busy_o(busy_o), .trunc_o(trunc_o)
  );

  always @(negedge clk) if (trunc_o === 1'b1) trunc_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

  // Write words on the load port; last flag on the final word if set_last
  task automatic load_pkt(input logic [DW-1:0] w[$], input bit set_last, output bit ok);
    int to;
    ok = 1'b1;
    foreach (w[i]) begin
      wr_data_i  = w[i];
      wr_last_i  = set_last && (i == w.size() - 1);
      wr_valid_i = 1'b1;
      to = 0;
      while (wr_ready_o !== 1'b1 && to < 200) begin
        @(negedge clk);
        to++;
      end
      if (to >= 200) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    wr_valid_i = 1'b0;
    wr_last_i  = 1'b0;
  endtask

  // Drive src_ready (0: always, 1: 1,0,0,1 pattern, 2: random) and record beats
  task automatic collect(input int mode, input int max_beats);
    bit r, prev_stall, done;
    logic [DW-1:0] pd;
    logic ps, pe;
    got_data.delete(); got_sop.delete(); got_eop.delete();
    first_valid = -1; last_beat = -1; stable_err = 0; wr_rdy_err = 0;
    prev_stall = 1'b0; done = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      case (mode)
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      src_ready_i = r;
      if (wr_ready_o !== 1'b0) wr_rdy_err++;
      if (src_valid_o === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall && (src_data_o !== pd || src_startofpacket_o !== ps || src_endofpacket_o !== pe))
          stable_err++;
        pd = src_data_o; ps = src_startofpacket_o; pe = src_endofpacket_o;
        prev_stall = !r;
        if (r) begin
          got_data.push_back(src_data_o);
          got_sop.push_back(src_startofpacket_o);
          got_eop.push_back(src_endofpacket_o);
          last_beat = cyc;
          if (src_endofpacket_o === 1'b1 || got_data.size() >= max_beats) begin
            @(negedge clk);
            done = 1'b1;
            break;
          end
        end
      end else begin
        if (prev_stall) stable_err++;
        prev_stall = 1'b0;
        if (src_startofpacket_o !== 1'b0 || src_endofpacket_o !== 1'b0) stable_err++;
      end
      @(negedge clk);
    end
    src_ready_i  = 1'b1;
    timeout_flag = !done;
  endtask

  task automatic test_reset();
    arst_n_i = 1'b0; wr_valid_i = 1'b0; wr_last_i = 1'b0; wr_data_i = '0; src_ready_i = 1'b1;
    #1;
    chk_cnt++;
    if ({src_valid_o, src_startofpacket_o, src_endofpacket_o, busy_o, trunc_o, wr_ready_o, src_data_o} !== '0) begin
      $display("FAIL reset_outputs: got v%b s%b e%b b%b t%b r%b d%h, expected all 0", src_valid_o,
               src_startofpacket_o, src_endofpacket_o, busy_o, trunc_o, wr_ready_o, src_data_o);
    end else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (wr_ready_o !== 1'b0) $display("FAIL reset_wr_ready_held: got %b expected 0", wr_ready_o);
    else pass_cnt++;
    arst_n_i = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (wr_ready_o !== 1'b1 || src_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL reset_release: got rdy%b v%b b%b expected rdy1 v0 b0", wr_ready_o, src_valid_o, busy_o);
    end else pass_cnt++;
  endtask

  // Load a packet and check the full replayed stream against the queue model
  task automatic test_stream(input string name, input logic [DW-1:0] w[$], input bit set_last, input int mode);
    bit ok;
    int n, t0, exp_trunc;
    n = w.size();
    exp_trunc = set_last ? 0 : 1;
    t0 = trunc_cnt;
    load_pkt(w, set_last, ok);
    chk_cnt++;
    if (!ok) $display("FAIL %s_load: wr_ready never high, expected %0d words accepted", name, n);
    else pass_cnt++;
    chk_cnt++;
    if (src_valid_o !== 1'b0 || busy_o !== 1'b1 || wr_ready_o !== 1'b0)
      $display("FAIL %s_prep: got v%b b%b rdy%b expected v0 b1 rdy0", name, src_valid_o, busy_o, wr_ready_o);
    else pass_cnt++;
    collect(mode, 1 << 30);
    chk_cnt++;
    if (timeout_flag) $display("FAIL %s_timeout: eop not seen, got %0d beats expected %0d", name, got_data.size(), n);
    else pass_cnt++;
    chk_cnt++;
    if (got_data.size() != n) $display("FAIL %s_count: got %0d beats expected %0d", name, got_data.size(), n);
    else pass_cnt++;
    for (int i = 0; i < n; i++) begin
      chk_cnt++;
      if (i >= got_data.size()) $display("FAIL %s_beat%0d: missing, expected data %h", name, i, w[i]);
      else if (got_data[i] !== w[i] || got_sop[i] !== (i == 0) || got_eop[i] !== (i == n - 1))
        $display("FAIL %s_beat%0d: got d%h s%b e%b expected d%h s%b e%b", name, i, got_data[i],
                 got_sop[i], got_eop[i], w[i], (i == 0), (i == n - 1));
      else pass_cnt++;
    end
    chk_cnt++;
    if (first_valid != 1) $display("FAIL %s_latency: first valid %0d cycles after load, expected 1", name, first_valid);
    else pass_cnt++;
    if (mode == 0) begin
      chk_cnt++;
      if (last_beat - first_valid + 1 != n)
        $display("FAIL %s_throughput: got %0d cycles expected %0d", name, last_beat - first_valid + 1, n);
      else pass_cnt++;
    end
    chk_cnt++;
    if (stable_err != 0) $display("FAIL %s_stall_hold: got %0d violations expected 0", name, stable_err);
    else pass_cnt++;
    chk_cnt++;
    if (wr_rdy_err != 0) $display("FAIL %s_wr_ready_busy: got %0d cycles high expected 0", name, wr_rdy_err);
    else pass_cnt++;
    chk_cnt++;
    if (src_valid_o !== 1'b0 || wr_ready_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL %s_post: got v%b rdy%b b%b expected v0 rdy1 b0", name, src_valid_o, wr_ready_o, busy_o);
    else pass_cnt++;
    chk_cnt++;
    if (trunc_cnt - t0 != exp_trunc) $display("FAIL %s_trunc: got %0d pulses expected %0d", name, trunc_cnt - t0, exp_trunc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w[$];
    logic [DW-1:0] w2[$];
    bit ok;
    for (int i = 0; i < 6; i++) w.push_back(DW'($urandom));
    load_pkt(w, 1'b1, ok);
    collect(0, 2);
    chk_cnt++;
    if (got_data.size() != 2 || src_valid_o !== 1'b1 || src_data_o !== w[2])
      $display("FAIL rstmid_pre: got %0d beats v%b d%h expected 2 beats v1 d%h", got_data.size(), src_valid_o, src_data_o, w[2]);
    else pass_cnt++;
    #2 arst_n_i = 1'b0;
    #1;
    chk_cnt++;
    if ({src_valid_o, src_startofpacket_o, src_endofpacket_o, busy_o, trunc_o, wr_ready_o, src_data_o} !== '0)
      $display("FAIL rstmid_async: got v%b s%b e%b b%b rdy%b d%h expected all 0", src_valid_o,
               src_startofpacket_o, src_endofpacket_o, busy_o, wr_ready_o, src_data_o);
    else pass_cnt++;
    @(negedge clk);
    arst_n_i = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (src_valid_o !== 1'b0 || src_endofpacket_o !== 1'b0 || wr_ready_o !== 1'b1)
      $display("FAIL rstmid_idle: got v%b e%b rdy%b expected v0 e0 rdy1", src_valid_o, src_endofpacket_o, wr_ready_o);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) w2.push_back(DW'($urandom));
    load_pkt(w2, 1'b1, ok);
    collect(0, 1 << 30);
    chk_cnt++;
    if (got_data.size() != 3) $display("FAIL rstmid_count: got %0d beats expected 3", got_data.size());
    else pass_cnt++;
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      chk_cnt++;
      if (got_data[i] !== w2[i] || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 2))
        $display("FAIL rstmid_beat%0d: got d%h s%b e%b expected d%h s%b e%b", i, got_data[i], got_sop[i],
                 got_eop[i], w2[i], (i == 0), (i == 2));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] p1[$];
    logic [DW-1:0] p2[$];
    bit ok;
    for (int i = 0; i < 2; i++) p1.push_back(DW'($urandom));
    for (int i = 0; i < 3; i++) p2.push_back(DW'($urandom));
    load_pkt(p1, 1'b1, ok);
    wr_valid_i = 1'b1; wr_last_i = 1'b1; wr_data_i = ~p1[0];
    collect(0, 1 << 30);
    wr_valid_i = 1'b0; wr_last_i = 1'b0;
    chk_cnt++;
    if (got_data.size() != 2 || got_data[0] !== p1[0] || got_data[1] !== p1[1] || got_sop[1] !== 1'b0 || got_eop[1] !== 1'b1)
      $display("FAIL b2b_first: got %0d beats first d%h expected 2 beats d%h,%h", got_data.size(), got_data[0], p1[0], p1[1]);
    else pass_cnt++;
    chk_cnt++;
    if (wr_rdy_err != 0) $display("FAIL b2b_wr_ready: got %0d cycles high expected 0", wr_rdy_err);
    else pass_cnt++;
    load_pkt(p2, 1'b1, ok);
    collect(0, 1 << 30);
    chk_cnt++;
    if (got_data.size() != 3 || first_valid != 1) $display("FAIL b2b_second: got %0d beats latency %0d expected 3 beats latency 1", got_data.size(), first_valid);
    else pass_cnt++;
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      chk_cnt++;
      if (got_data[i] !== p2[i] || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 2))
        $display("FAIL b2b_beat%0d: got d%h s%b e%b expected d%h s%b e%b", i, got_data[i], got_sop[i],
                 got_eop[i], p2[i], (i == 0), (i == 2));
      else pass_cnt++;
    end
  endtask

  initial begin
    logic [DW-1:0] w[$];
    test_reset();
    w = '{8'd5, 8'd3, 8'd9, 8'd1};
    test_stream("basic", w, 1'b1, 0);
    w = '{8'hA5};
    test_stream("single", w, 1'b1, 0);
    w = '{8'd5, 8'd3, 8'd9, 8'd1};
    test_stream("backpressure", w, 1'b1, 1);
    for (int p = 0; p < 4; p++) begin
      int len;
      w.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) w.push_back(DW'($urandom));
      test_stream("random", w, 1'b1, 2);
    end
    w.delete();
    for (int i = 0; i < MAXL; i++) w.push_back(DW'(i));
    test_stream("trunc", w, 1'b0, 0);
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
